// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums i_max_ci conv2d passes per output pixel, then drains scaled/saturated ofmap.
// Optional build macro PSUM_RELU_EN: clamp negative drained values to zero before saturation.
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_PIX    = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8:0]            i_max_width,
  input  logic [8:0]            i_max_height,
  input  logic [9:0]            i_max_ci,
  input  logic [3:0]            i_frac_bits,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_done,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_done,
  output logic                  o_busy,
  output logic [9:0]            o_ci_cnt,
  output logic                  o_err
);

  localparam int NPIX_W = 18;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NPIX_W-1:0]            r_npix;
  logic [9:0]                   r_max_ci;
  logic [3:0]                   r_frac;
  logic [NPIX_W-1:0]            r_addr;
  logic [9:0]                   r_ci_cnt;
  logic [NPIX_W-1:0]            r_tx_cnt;
  logic                         r_err;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_oval;
  logic [DATA_WIDTH-1:0]        r_odata;
  logic                         r_dr_v;
  logic signed [ACC_WIDTH-1:0]  r_rd_data;
  logic                         r_p_valid;
  logic [ADDR_WIDTH-1:0]        r_p_addr;
  logic [DATA_WIDTH-1:0]        r_p_data;
  logic                         r_p_first;
  logic [ACC_WIDTH-1:0]         r_mem [0:MAX_PIX-1];

  logic                         w_beat;
  logic                         w_drop;
  logic [NPIX_W-1:0]            w_beats;
  logic [9:0]                   w_ci_nxt;
  logic signed [ACC_WIDTH-1:0]  w_p_ext;
  logic                         w_wr_en;
  logic signed [ACC_WIDTH-1:0]  w_wr_data;
  logic                         w_out_adv;
  logic                         w_dr_load;
  logic                         w_dr_issue;
  logic                         w_rd_en;
  logic [ADDR_WIDTH-1:0]        w_rd_addr;
  logic signed [ACC_WIDTH-1:0]  w_rd_data;
  logic                         w_tx;
  logic                         w_last_tx;
  logic signed [ACC_WIDTH-1:0]  w_shift;
  logic signed [ACC_WIDTH-1:0]  w_relu;
  logic [DATA_WIDTH-1:0]        w_sat;

  assign o_data   = r_odata;
  assign o_valid  = r_oval;
  assign o_done   = r_done;
  assign o_busy   = r_busy;
  assign o_ci_cnt = r_ci_cnt;
  assign o_err    = r_err;

  always_comb begin
    w_beat     = (r_state == S_ACC) && i_valid && (r_addr < r_npix);
    w_drop     = (r_state == S_ACC) && i_valid && (r_addr >= r_npix);
    w_beats    = r_addr + (w_beat ? 18'd1 : 18'd0);
    w_ci_nxt   = r_ci_cnt + 10'd1;
    w_p_ext    = {{(ACC_WIDTH-DATA_WIDTH){r_p_data[DATA_WIDTH-1]}}, r_p_data};
    w_wr_en    = r_p_valid;
    w_wr_data  = r_p_first ? w_p_ext : (r_rd_data + w_p_ext);
    w_out_adv  = !r_oval || i_out_ready;
    w_dr_load  = !r_dr_v || w_out_adv;
    w_dr_issue = (r_state == S_DRAIN) && (r_addr < r_npix) && w_dr_load;
    w_rd_en    = w_beat || w_dr_issue;
    w_rd_addr  = r_addr[ADDR_WIDTH-1:0];
    // A write retiring this cycle is not yet visible in the array, so bypass it.
    w_rd_data  = (w_wr_en && (r_p_addr == w_rd_addr)) ? w_wr_data
                                                      : $signed(r_mem[w_rd_addr]);
    w_tx       = r_oval && i_out_ready;
    w_last_tx  = (r_state == S_DRAIN) && w_tx && (r_tx_cnt == (r_npix - 18'd1));
  end

  always_comb begin
    w_shift = r_rd_data >>> r_frac;
`ifdef PSUM_RELU_EN
    w_relu  = w_shift[ACC_WIDTH-1] ? '0 : w_shift;
`else
    w_relu  = w_shift;
`endif
    if (w_relu > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_relu < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_relu[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_ACC;
        else         w_state_nxt = S_IDLE;
      end
      S_ACC: begin
        if (i_done && (w_ci_nxt == r_max_ci)) w_state_nxt = S_DRAIN;
        else                                  w_state_nxt = S_ACC;
      end
      S_DRAIN: begin
        if (w_last_tx) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_npix   <= '0;
      r_max_ci <= '0;
      r_frac   <= '0;
      r_addr   <= '0;
      r_ci_cnt <= '0;
      r_tx_cnt <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last_tx;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_npix   <= {9'd0, i_max_width} * {9'd0, i_max_height};
            r_max_ci <= i_max_ci;
            r_frac   <= i_frac_bits;
            r_addr   <= '0;
            r_ci_cnt <= '0;
            r_tx_cnt <= '0;
            r_err    <= 1'b0;
          end
        end
        S_ACC: begin
          if (w_drop) r_err <= 1'b1;
          // A beat coinciding with i_done is the closing beat of this pass.
          if (i_done) begin
            if (w_beats != r_npix) r_err <= 1'b1;
            r_ci_cnt <= w_ci_nxt;
            r_addr   <= '0;
          end else if (w_beat) begin
            r_addr <= r_addr + 18'd1;
          end
        end
        S_DRAIN: begin
          if (i_valid)    r_err    <= 1'b1;
          if (w_dr_issue) r_addr   <= r_addr + 18'd1;
          if (w_tx)       r_tx_cnt <= r_tx_cnt + 18'd1;
        end
        default: r_addr <= '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_p_addr] <= w_wr_data;
    if (w_rd_en) r_rd_data <= w_rd_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_valid <= 1'b0;
      r_p_addr  <= '0;
      r_p_data  <= '0;
      r_p_first <= 1'b0;
    end else begin
      r_p_valid <= w_beat;
      r_p_addr  <= r_addr[ADDR_WIDTH-1:0];
      r_p_data  <= i_data;
      r_p_first <= (r_ci_cnt == 10'd0);
    end
  end

  // Read stage and output register form a stallable two-stage drain pipe.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_last_tx) begin
      r_dr_v  <= 1'b0;
      r_oval  <= 1'b0;
      r_odata <= '0;
    end else begin
      if (w_dr_load) r_dr_v <= w_dr_issue;
      if (w_out_adv) begin
        r_oval <= r_dr_v;
        if (r_dr_v) r_odata <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: directed scenarios, monitor pops expected samples on handshake.
module tb_psum_accumulator;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_start = 1'b0;
  logic [8:0]         i_max_width = 9'd0;
  logic [8:0]         i_max_height = 9'd0;
  logic [9:0]         i_max_ci = 10'd0;
  logic [3:0]         i_frac_bits = 4'd0;
  logic signed [15:0] i_data = 16'sd0;
  logic               i_valid = 1'b0;
  logic               i_done = 1'b0;
  logic               i_out_ready = 1'b1;
  logic signed [15:0] o_data;
  logic               o_valid;
  logic               o_done;
  logic               o_busy;
  logic [9:0]         o_ci_cnt;
  logic               o_err;

  psum_accumulator dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_max_width(i_max_width), .i_max_height(i_max_height),
    .i_max_ci(i_max_ci), .i_frac_bits(i_frac_bits),
    .i_data(i_data), .i_valid(i_valid), .i_done(i_done),
    .i_out_ready(i_out_ready),
    .o_data(o_data), .o_valid(o_valid), .o_done(o_done),
    .o_busy(o_busy), .o_ci_cnt(o_ci_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_pop = 0;
  int t_first = 0;
  int t_last = 0;
  int exp_q[$];
  int pv[$];
  bit done_exp = 1'b0;
  bit stalled = 1'b0;
  logic signed [15:0] held = 16'sd0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every accepted sample with the scoreboard, checks stall hold and o_done timing.
  always @(negedge clk) begin
    if (done_exp) begin
      chk("done_pulse", o_done, 1);
      chk("busy_after_done", o_busy, 0);
      done_exp = 1'b0;
    end else if (o_done) begin
      chk("spurious_done", o_done, 0);
    end
    if (stalled) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_data", o_data, held);
    end
    stalled = o_valid && !i_out_ready;
    held = o_data;
    if (o_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_sample", o_data, 99999);
      end else begin
        chk("o_data", o_data, exp_q.pop_front());
        n_pop++;
        if (n_pop == 1) t_first = cyc;
        t_last = cyc;
        if (exp_q.size() == 0) done_exp = 1'b1;
      end
    end
  end

  task automatic run(int w, int h, int ci, int frac, int npass);
    n_pop = 0;
    step();
    i_start = 1'b1;
    i_max_width = 9'(w);
    i_max_height = 9'(h);
    i_max_ci = 10'(ci);
    i_frac_bits = 4'(frac);
    step();
    i_start = 1'b0;
    for (int p = 0; p < npass; p++) begin
      for (int b = 0; b < pv.size(); b++) begin
        i_valid = 1'b1;
        i_data = 16'(pv[b]);
        i_done = (b == pv.size() - 1);
        step();
      end
    end
    i_valid = 1'b0;
    i_done = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < 200) begin
      step();
      k++;
    end
    chk({nm, "_completed"}, (k < 200), 1);
    step();
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) step();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_done", o_done, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_o_ci_cnt", o_ci_cnt, 0);
    chk("rst_o_err", o_err, 0);
    chk("rst_o_data", o_data, 0);
    i_rst = 1'b0;

    // 2x2, one pass
    pv = '{1, 2, 3, 4};
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    run(2, 2, 1, 0, 1);
    wait_drain("s1");
    chk("s1_consecutive", t_last - t_first, 3);
    chk("s1_err", o_err, 0);
    chk("s1_ci_cnt", o_ci_cnt, 1);

    // 2x2, three back-to-back passes
    pv = '{100, -50, 7, 0};
    exp_q.push_back(300); exp_q.push_back(-150); exp_q.push_back(21); exp_q.push_back(0);
    run(2, 2, 3, 0, 3);
    wait_drain("s2");
    chk("s2_ci_cnt", o_ci_cnt, 3);
    chk("s2_err", o_err, 0);

    // 1x1 with forwarding, positive saturation
    pv = '{30000};
    exp_q.push_back(32767);
    run(1, 1, 2, 0, 2);
    wait_drain("s3");

    // 1x1 negative saturation
    pv = '{-30000};
    exp_q.push_back(-32768);
    run(1, 1, 2, 0, 2);
    wait_drain("s4");

    // 1x1, four single-beat passes on consecutive cycles
    pv = '{1};
    exp_q.push_back(4);
    run(1, 1, 4, 0, 4);
    wait_drain("s5");
    chk("s5_ci_cnt", o_ci_cnt, 4);

    // 1x2, frac=2 floor shift
    pv = '{-5, 9};
`ifdef PSUM_RELU_EN
    exp_q.push_back(0);
`else
    exp_q.push_back(-2);
`endif
    exp_q.push_back(2);
    run(1, 2, 1, 2, 1);
    wait_drain("s6");

    // 2x2 with a 3-cycle stall after the 2nd sample is presented
    pv = '{1, 2, 3, 4};
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    run(2, 2, 1, 0, 1);
    k = 0;
    while (n_pop < 1 && k < 50) begin
      step();
      k++;
    end
    chk("s7_first_sample_seen", (k < 50), 1);
    i_out_ready = 1'b0;
    repeat (3) step();
    i_out_ready = 1'b1;
    wait_drain("s7");
    chk("s7_count", n_pop, 4);

    // short pass flags an error; reset mid-ACC then a clean rerun
    pv = '{1, 2, 3};
    run(2, 2, 2, 0, 1);
    step();
    chk("s8_err", o_err, 1);
    chk("s8_ci_cnt", o_ci_cnt, 1);
    chk("s8_busy", o_busy, 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("s8_rst_busy", o_busy, 0);
    chk("s8_rst_valid", o_valid, 0);
    chk("s8_rst_err", o_err, 0);
    chk("s8_rst_ci_cnt", o_ci_cnt, 0);

    pv = '{1, 2, 3, 4};
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    run(2, 2, 1, 0, 1);
    wait_drain("s9");
    chk("s9_consecutive", t_last - t_first, 3);
    chk("s9_err", o_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
